// File: rtl/smult_accumulator.sv
// Signed product accumulator behind the registered multiplier.
// Ports: clk, rst, op_valid/op_first/op_last, product -> acc_out, acc_valid, acc_sat, busy.
module smult_accumulator #(
   parameter int N        = 8,
   parameter int MULT_LAT = 2,
   parameter int GUARD    = 4,
   parameter int FRAC     = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  op_valid,
   input  logic                  op_first,
   input  logic                  op_last,
   input  logic signed [2*N-1:0] product,
   output logic signed [N-1:0]   acc_out,
   output logic                  acc_valid,
   output logic                  acc_sat,
   output logic                  busy
);

   localparam int AW = 2*N + GUARD;

   localparam logic signed [AW-1:0] SMAX =
      {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [AW-1:0] SMIN =
      {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};

   logic [MULT_LAT-1:0] sv;
   logic [MULT_LAT-1:0] sf;
   logic [MULT_LAT-1:0] sl;

   logic d_valid;
   logic d_first;
   logic d_last;

   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] acc_nxt;
   logic signed [AW-1:0] pext;
   logic signed [AW-1:0] shifted;
   logic signed [N-1:0]  res;
   logic                 res_sat;
   logic                 sat_hi;
   logic                 sat_lo;
   logic                 grp_open;

   assign d_valid = sv[MULT_LAT-1];
   assign d_first = sf[MULT_LAT-1];
   assign d_last  = sl[MULT_LAT-1];

   // Tags travel alongside the operands so they line up with product.
   always_ff @(posedge clk) begin
      if (rst) begin
         sv <= '0;
         sf <= '0;
         sl <= '0;
      end else begin
         sv[0] <= op_valid;
         sf[0] <= op_valid & op_first;
         sl[0] <= op_valid & op_last;
         for (int i = 1; i < MULT_LAT; i++) begin
            sv[i] <= sv[i-1];
            sf[i] <= sf[i-1];
            sl[i] <= sl[i-1];
         end
      end
   end

   assign pext = AW'(product);

   always_comb begin
      acc_nxt = acc;
      if (d_valid) begin
         if (d_first) acc_nxt = pext;
         else         acc_nxt = acc + pext;
      end
   end

   // Result is taken from the updated sum, so a single-product
   // group needs no extra cycle.
   assign shifted = acc_nxt >>> FRAC;
   assign sat_hi  = shifted > SMAX;
   assign sat_lo  = shifted < SMIN;

   always_comb begin
      res     = shifted[N-1:0];
      res_sat = 1'b0;
      unique case (1'b1)
         sat_hi: begin
            res     = SMAX[N-1:0];
            res_sat = 1'b1;
         end
         sat_lo: begin
            res     = SMIN[N-1:0];
            res_sat = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         grp_open  <= 1'b0;
         acc_out   <= '0;
         acc_sat   <= 1'b0;
         acc_valid <= 1'b0;
      end else begin
         acc       <= acc_nxt;
         acc_valid <= d_valid & d_last;
         if (d_valid & d_last) begin
            acc_out  <= res;
            acc_sat  <= res_sat;
            grp_open <= 1'b0;
         end else if (d_valid & d_first) begin
            grp_open <= 1'b1;
         end
      end
   end

   assign busy = (|sv) | grp_open;

endmodule
